// File: rtl/board_cursor_ctrl.sv
// Battleship input stage: conditions the move/place buttons, keeps a wrapping board cursor
// and records ship placement for the game FSM.
module board_cursor_ctrl #(
    parameter int BOARD_N   = 5,
    parameter int DB_CYCLES = 250000,
    parameter int MAX_SHIPS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         move_up,
    input  logic                         move_down,
    input  logic                         move_left,
    input  logic                         move_right,
    input  logic                         player_place_ship,
    input  logic [2:0]                   amount_of_ships,
    output logic [2:0]                   i_actual,
    output logic [2:0]                   j_actual,
    output logic [BOARD_N*BOARD_N-1:0]   ship_map,
    output logic [2:0]                   ships_placed,
    output logic                         place_ok,
    output logic                         place_err,
    output logic                         finished_placing
);
    localparam int               CELLS    = BOARD_N * BOARD_N;
    localparam int               NBTN     = 5;
    localparam int               CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [2:0]       LAST     = 3'(BOARD_N - 1);

    typedef enum logic [1:0] {IDLE, PLACING, DONE} state_t;

    // Button order: 0 up, 1 down, 2 left, 3 right, 4 place.
    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] db;
    logic [NBTN-1:0] db_prev;
    logic [NBTN-1:0] press;

    assign raw = {player_place_ship, move_right, move_left, move_down, move_up};

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            db_prev <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db;
        end
    end

    // The level only follows the synchronized input after DB_CYCLES unbroken cycles of disagreement.
    for (genvar b = 0; b < NBTN; b++) begin : g_btn
        logic [CNT_W-1:0] cnt;
        logic             level;

        always_ff @(posedge clk) begin
            if (!rst) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync2[b] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2[b];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign db[b] = level;
    end

    assign press = db & ~db_prev;

    logic go_up, go_down, go_left, go_right, place_pulse;

    assign go_up       = press[0] & ~press[1];
    assign go_down     = press[1] & ~press[0];
    assign go_left     = press[2] & ~press[3];
    assign go_right    = press[3] & ~press[2];
    assign place_pulse = press[4];

    // The cursor is live in every state; it is reused for aiming shots.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_actual <= '0;
            j_actual <= '0;
        end else begin
            if (go_up)
                i_actual <= (i_actual == 3'd0) ? LAST : i_actual - 3'd1;
            else if (go_down)
                i_actual <= (i_actual == LAST) ? 3'd0 : i_actual + 3'd1;

            if (go_left)
                j_actual <= (j_actual == 3'd0) ? LAST : j_actual - 3'd1;
            else if (go_right)
                j_actual <= (j_actual == LAST) ? 3'd0 : j_actual + 3'd1;
        end
    end

    state_t           state, state_next;
    logic [2:0]       target, target_next, clamped;
    logic [CELLS-1:0] map_next, cell_mask;
    logic [2:0]       count_next;
    logic             ok_next, err_next, occupied;

    assign clamped   = (int'(amount_of_ships) > MAX_SHIPS) ? 3'(MAX_SHIPS) : amount_of_ships;
    assign cell_mask = CELLS'(1) << (int'(i_actual) * BOARD_N + int'(j_actual));
    assign occupied  = |(ship_map & cell_mask);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = PLACING;
                PLACING: if (ships_placed == target) state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    // The place pulse looks at the pre-move cursor, since the cursor registers update on the same edge.
    always_comb begin
        map_next    = ship_map;
        count_next  = ships_placed;
        target_next = target;
        ok_next     = 1'b0;
        err_next    = 1'b0;

        if (place_pulse) begin
            if (state == PLACING && ships_placed != target && !occupied) begin
                map_next   = ship_map | cell_mask;
                count_next = ships_placed + 3'd1;
                ok_next    = 1'b1;
            end else begin
                err_next = 1'b1;
            end
        end

        if (state == IDLE && enable) begin
            map_next    = '0;
            count_next  = '0;
            target_next = clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ship_map     <= '0;
            ships_placed <= '0;
            target       <= '0;
            place_ok     <= 1'b0;
            place_err    <= 1'b0;
        end else begin
            ship_map     <= map_next;
            ships_placed <= count_next;
            target       <= target_next;
            place_ok     <= ok_next;
            place_err    <= err_next;
        end
    end

    assign finished_placing = (state == DONE);

endmodule
